bch_enc_lfsr_stream: RTL and testbench
======================================

Name: bch_enc_lfsr_stream

Overview:
Systematic binary BCH encoder, 1 bit/cycle, frame-based. It is the transmit-side counterpart of the syndrome / Berlekamp / Chien decode chain. Data bits pass straight to the output while a generator-polynomial LFSR accumulates the remainder; the parity bits are then shifted out MSB first. Shortened codes (k < k_max) are supported through early ieop.

Parameters:
m, 4, GF(2^m) field order
k_max, 7, maximum number of data bits per frame
d, 5, code distance (t = (d-1)/2)
n, 15, full codeword length
irrpol, 19, field primitive polynomial (x^4+x+1)

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
iclkena  in  1  clock enable; all state frozen when low
isop  in  1  first data bit of frame
ival  in  1  data bit valid
ieop  in  1  last data bit of frame
idat  in  1  data bit, MSB (highest power) first
ordy  out  1  encoder accepts data this cycle
osop  out  1  first codeword bit
oval  out  1  codeword bit valid
oeop  out  1  last parity bit
odat  out  1  codeword bit

Behaviour:
- Single clock iclk; reset is synchronous and active-high on ireset.
- Everything is gated by iclkena, except ireset, which acts on any iclk edge.
- Reset values: osop=oval=oeop=odat=0; ordy=0 in the cycle after reset; LFSR=0; cnt=0; state=cRESET.
- g(x) has degree P = deg(LCM of the minimal polynomials of alpha^1..alpha^2t). P is computed at elaboration. Default g = x^8+x^7+x^6+x^4+1, P=8.
- FSM cRESET -> cDATA (unconditional). cDATA -> cPARITY on an accepted last bit. cPARITY -> cDATA when the parity counter reaches 0.
- ordy = (state==cDATA). A bit is accepted when ival & ordy & iclkena.
- An accepted bit with isop clears the LFSR first: the feedback uses a zero register.
- Feedback fb = idat ^ r[P-1]; r <= {r[P-2:0],0} ^ (fb ? g[P-1:0] : 0).
- The data counter cnt starts at 0 and increments per accepted bit.
- Last bit is ieop, or cnt==k_max-1 (forced end; ieop after that is ignored).
- Accepted bits are echoed one cycle later: oval=1, odat=idat, osop=isop, oeop=0. Latency is exactly 1 cycle.
- cPARITY lasts P cycles. Each cycle: odat=r[P-1], r shifts left with zero fill, oval=1. oeop=1 on the P-th bit.
- ordy=0 throughout cPARITY. The output stream has no gaps, independent of ival.
- Back-to-back frames: ordy rises in the cycle after the last parity bit is launched. A new isop bit may be accepted then, so there are zero idle output cycles between frames.
- ival without a prior isop (mid-idle) is encoded into the current LFSR (no error flag). The upstream side is responsible for framing.
- isop and ieop together: a 1-bit frame, followed by the P parity bits of that bit.
- ireset mid-frame aborts: outputs go 0 on the next edge and the partial codeword is never completed.
- Shortened code: leading zeros do not change the remainder, so k<k_max needs no special handling. Codeword length = k+P.

Decomposition:
- bch_parameters.svh: t, t2, P (cGEN_DEG), data_t.
- bch_functions.svh: gf_mult_a_by_b and the elaboration-time function gen_poly() (minimal-polynomial product), shared with the decoder for consistency checks.
- Sub-module bch_enc_lfsr: holds the P-bit register with clear, shift_in (data mode) and shift_out (parity mode) controls. The top level holds the FSM, counters and output registers.

Test Plan:
- Message 0000001 (isop on bit0, ieop on bit6) -> odat 000000111010001 over 15 consecutive cycles; oeop on the 15th bit; osop on the 1st.
- Message 1111111 -> 15 ones; parity 11111111.
- All-zero message, then an immediate back-to-back frame 0000001 -> 30 contiguous oval cycles. The second osop arrives right after the first oeop; ordy is low for exactly 8 cycles per frame.
- Shortened frame of 3 bits 001 (ieop on bit2) -> output 001 11010001, 11 bits total, matching the tail of the full-length case.
- No ieop for 9 bits -> encoding is forced to end after bit 7; bits 8-9 are not accepted (ordy=0); parity 11010001 follows message 0000001.
- ireset asserted at parity bit 3 -> next cycle oval=0; after release, frame 0000001 encodes correctly (LFSR fully cleared). Also: iclkena low for 5 cycles mid-parity -> output stalls and then resumes with an identical bit sequence.

Source files
------------

// File: rtl/bch_enc_lfsr_stream_pkg.sv
// Shared types and elaboration-time GF(2^m) helpers for the BCH encoder.
// gen_poly() builds g(x) as the LCM of the minimal polynomials of alpha^1..alpha^2t.
package bch_enc_lfsr_stream_pkg;

   localparam int unsigned GEN_MAX = 32;

   typedef logic [GEN_MAX:0] gen_t;
   typedef logic data_t;

   typedef enum logic [1:0] {
      cRESET,
      cDATA,
      cPARITY
   } state_t;

   function automatic int unsigned gf_mult_a_by_b(input int unsigned a, input int unsigned b,
                                                  input int unsigned m, input int unsigned irrpol);
      int unsigned p;
      int unsigned x;
      p = 0;
      x = a;
      for (int unsigned i = 0; i < m; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ x;
         x = x << 1;
         if (((x >> m) & 1) != 0) x = x ^ irrpol;
      end
      return p;
   endfunction

   // Product of (x + alpha^j) over the union of the cyclotomic classes of 1..2t; the
   // coefficients land in GF(2), so only bit 0 of each survives.
   function automatic gen_t gen_poly(input int unsigned m, input int unsigned n,
                                     input int unsigned d, input int unsigned irrpol);
      int unsigned coef [GEN_MAX+1];
      logic [63:0] mark;
      int unsigned e;
      int unsigned a;
      int unsigned t2;
      gen_t        g;
      for (int k = 0; k <= GEN_MAX; k++) coef[k] = 0;
      coef[0] = 1;
      mark    = '0;
      t2      = 2 * ((d - 1) / 2);
      for (int unsigned i = 1; i <= t2; i++) begin
         e = i % n;
         for (int unsigned j = 0; j < m; j++) begin
            mark = mark | (64'd1 << e);
            e    = (e * 2) % n;
         end
      end
      a = 1;
      for (int unsigned j = 0; j < n; j++) begin
         if (((mark >> j) & 64'd1) != 64'd0) begin
            for (int k = GEN_MAX; k > 0; k--) begin
               coef[k] = coef[k-1] ^ gf_mult_a_by_b(coef[k], a, m, irrpol);
            end
            coef[0] = gf_mult_a_by_b(coef[0], a, m, irrpol);
         end
         a = gf_mult_a_by_b(a, 2, m, irrpol);
      end
      g = '0;
      for (int k = 0; k <= GEN_MAX; k++) g[k] = ((coef[k] & 1) != 0);
      return g;
   endfunction

   function automatic int unsigned poly_deg(input gen_t g);
      int unsigned deg;
      deg = 0;
      for (int i = 0; i <= GEN_MAX; i++) if (g[i]) deg = i;
      return deg;
   endfunction

endpackage

// File: rtl/bch_enc_lfsr_stream_lfsr.sv
// P-bit generator-polynomial remainder register: absorbs data bits MSB first,
// then shifts the remainder out MSB first with zero fill.
module bch_enc_lfsr_stream_lfsr #(
   parameter int unsigned     P = 8,
   parameter logic [P-1:0]    G = 8'hD1
) (
   input  logic iclk,
   input  logic ireset,
   input  logic clear,
   input  logic shift_in,
   input  logic shift_out,
   input  logic din,
   output logic msb
);

   logic [P-1:0] r_q;
   logic [P-1:0] base;
   logic         fb;

   // A start-of-frame bit is folded into a zeroed register rather than the stale remainder.
   always_comb begin
      base = clear ? '0 : r_q;
      fb   = din ^ base[P-1];
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_q <= '0;
      end else if (shift_in) begin
         r_q <= {base[P-2:0], 1'b0} ^ (fb ? G : '0);
      end else if (shift_out) begin
         r_q <= {r_q[P-2:0], 1'b0};
      end
   end

   assign msb = r_q[P-1];

endmodule

// File: rtl/bch_enc_lfsr_stream.sv
// Systematic serial BCH encoder: data bits pass through with one cycle of latency,
// then the P parity bits follow back to back.
module bch_enc_lfsr_stream
   import bch_enc_lfsr_stream_pkg::*;
#(
   parameter int unsigned m      = 4,
   parameter int unsigned k_max  = 7,
   parameter int unsigned d      = 5,
   parameter int unsigned n      = 15,
   parameter int unsigned irrpol = 19
) (
   input  logic iclk,
   input  logic ireset,
   input  logic iclkena,
   input  logic isop,
   input  logic ival,
   input  logic ieop,
   input  logic idat,
   output logic ordy,
   output logic osop,
   output logic oval,
   output logic oeop,
   output logic odat
);

   localparam gen_t        cGEN     = gen_poly(m, n, d, irrpol);
   localparam int unsigned cGEN_DEG = poly_deg(cGEN);
   localparam int unsigned cCNT_W   = (k_max > 2) ? $clog2(k_max) : 1;
   localparam int unsigned cPCNT_W  = (cGEN_DEG > 2) ? $clog2(cGEN_DEG) : 1;

   state_t              state_q;
   logic [cCNT_W-1:0]   cnt_q;
   logic [cCNT_W-1:0]   cnt_base;
   logic [cPCNT_W-1:0]  pcnt_q;
   logic                osop_q, oval_q, oeop_q, odat_q;
   logic                accept;
   logic                last_bit;
   logic                lfsr_msb;

   assign ordy     = (state_q == cDATA);
   assign accept   = ival & ordy & iclkena;
   // isop restarts the count so a frame can never inherit a stale position.
   assign cnt_base = isop ? '0 : cnt_q;
   assign last_bit = ieop | (cnt_base == cCNT_W'(k_max - 1));

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state_q <= cRESET;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         osop_q  <= 1'b0;
         oval_q  <= 1'b0;
         oeop_q  <= 1'b0;
         odat_q  <= 1'b0;
      end else if (iclkena) begin
         osop_q <= 1'b0;
         oval_q <= 1'b0;
         oeop_q <= 1'b0;
         odat_q <= 1'b0;
         unique case (state_q)
            cRESET: state_q <= cDATA;
            cDATA: begin
               if (ival) begin
                  oval_q <= 1'b1;
                  odat_q <= idat;
                  osop_q <= isop;
                  if (last_bit) begin
                     state_q <= cPARITY;
                     cnt_q   <= '0;
                     pcnt_q  <= cPCNT_W'(cGEN_DEG - 1);
                  end else begin
                     cnt_q <= cnt_base + 1'b1;
                  end
               end
            end
            cPARITY: begin
               oval_q <= 1'b1;
               odat_q <= lfsr_msb;
               if (pcnt_q == '0) begin
                  oeop_q  <= 1'b1;
                  state_q <= cDATA;
               end else begin
                  pcnt_q <= pcnt_q - 1'b1;
               end
            end
            default: state_q <= cRESET;
         endcase
      end
   end

   bch_enc_lfsr_stream_lfsr #(
      .P (cGEN_DEG),
      .G (cGEN[cGEN_DEG-1:0])
   ) u_lfsr (
      .iclk      (iclk),
      .ireset    (ireset),
      .clear     (accept & isop),
      .shift_in  (accept),
      .shift_out (iclkena & (state_q == cPARITY)),
      .din       (idat),
      .msb       (lfsr_msb)
   );

   assign osop = osop_q;
   assign oval = oval_q;
   assign oeop = oeop_q;
   assign odat = odat_q;

endmodule

// File: tb/tb_bch_enc_lfsr_stream.sv
// Scoreboard bench for the serial BCH(15,7) encoder using hand-computed codewords.
module tb_bch_enc_lfsr_stream;

   logic iclk, ireset, iclkena, isop, ival, ieop, idat;
   logic ordy, osop, oval, oeop, odat;

   typedef struct packed {
      logic sop;
      logic eop;
      logic dat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   logic en_at_edge = 1'b0;
   int   run = 0;
   int   last_run = 0;
   int   ordy_low = 0;

   bch_enc_lfsr_stream dut (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .isop    (isop),
      .ival    (ival),
      .ieop    (ieop),
      .idat    (idat),
      .ordy    (ordy),
      .osop    (osop),
      .oval    (oval),
      .oeop    (oeop),
      .odat    (odat)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic [31:0] w, input int len, input bit with_eop);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         e.sop = (i == 0);
         e.eop = with_eop && (i == len - 1);
         e.dat = w[len-1-i];
         q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic wait_ordy();
      int k = 0;
      while (!ordy && k < 50) begin
         tick();
         k++;
      end
      if (!ordy) check("wait_ordy_timeout", 32'(ordy), 32'd1);
   endtask

   // Bits go out MSB first; from noacc_from on the encoder must not be accepting.
   task automatic send_frame(input logic [31:0] bits, input int len, input int eop_at,
                             input int noacc_from);
      wait_ordy();
      for (int i = 0; i < len; i++) begin
         isop = (i == 0);
         ieop = (i == eop_at);
         idat = bits[len-1-i];
         ival = 1'b1;
         if (i >= noacc_from) check("ordy_low_after_forced_end", 32'(ordy), 32'd0);
         tick();
      end
      ival = 1'b0;
      isop = 1'b0;
      ieop = 1'b0;
      idat = 1'b0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (q.size() != 0 && k < 60) begin
         tick();
         k++;
      end
      check(name, 32'(q.size()), 32'd0);
      repeat (2) tick();
   endtask

   initial begin
      forever begin
         @(posedge iclk);
         en_at_edge = iclkena;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge iclk);
         if (en_at_edge) begin
            if (!ordy) ordy_low++;
            if (oval) begin
               run++;
               n_cmp++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output: got sop/eop/dat %b%b%b expected none",
                           osop, oeop, odat);
               end else begin
                  e = q.pop_front();
                  if ({osop, oeop, odat} !== {e.sop, e.eop, e.dat}) begin
                     n_fail++;
                     $display("FAIL stream_bit: got sop/eop/dat %b%b%b expected %b%b%b",
                              osop, oeop, odat, e.sop, e.eop, e.dat);
                  end
               end
            end else begin
               if (run != 0) last_run = run;
               run = 0;
            end
         end
      end
   end

   initial begin
      ireset  = 1'b1;
      iclkena = 1'b1;
      isop    = 1'b0;
      ival    = 1'b0;
      ieop    = 1'b0;
      idat    = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {27'd0, ordy, osop, oval, oeop, odat}, 32'd0);
      ireset = 1'b0;
      check("ordy_low_after_reset", 32'(ordy), 32'd0);
      tick();
      check("ordy_high_in_data", 32'(ordy), 32'd1);

      // Message 0000001 -> parity 11010001
      push_exp(32'b000000111010001, 15, 1'b1);
      send_frame(32'b0000001, 7, 6, 99);
      drain("drain_msg1");

      push_exp(32'h7FFF, 15, 1'b1);
      send_frame(32'b1111111, 7, 6, 99);
      drain("drain_all_ones");

      // Back-to-back frames must produce one unbroken 30-bit burst.
      ordy_low = 0;
      push_exp(32'b0, 15, 1'b1);
      push_exp(32'b000000111010001, 15, 1'b1);
      send_frame(32'b0000000, 7, 6, 99);
      send_frame(32'b0000001, 7, 6, 99);
      drain("drain_back_to_back");
      check("back_to_back_run", 32'(last_run), 32'd30);
      check("ordy_low_cycles", 32'(ordy_low), 32'd16);

      push_exp(32'b00111010001, 11, 1'b1);
      send_frame(32'b001, 3, 2, 99);
      drain("drain_shortened");

      // No ieop: the frame is closed after bit 7, bits 8 and 9 are refused.
      push_exp(32'b000000111010001, 15, 1'b1);
      send_frame(32'b000000111, 9, -1, 7);
      drain("drain_forced_end");

      // Reset during parity: only the first two parity bits (1,1) ever appear.
      push_exp(32'b000000111, 9, 1'b0);
      send_frame(32'b0000001, 7, 6, 99);
      tick();
      tick();
      ireset = 1'b1;
      tick();
      check("oval_after_abort", 32'(oval), 32'd0);
      check("queue_after_abort", 32'(q.size()), 32'd0);
      ireset = 1'b0;
      push_exp(32'b000000111010001, 15, 1'b1);
      send_frame(32'b0000001, 7, 6, 99);
      drain("drain_after_abort");

      // Clock-enable stall after parity bit 3 (a 0) must hold the output.
      push_exp(32'b000000111010001, 15, 1'b1);
      send_frame(32'b0000001, 7, 6, 99);
      repeat (3) tick();
      iclkena = 1'b0;
      repeat (5) tick();
      check("stall_hold", {30'd0, oval, odat}, 32'b10);
      iclkena = 1'b1;
      drain("drain_stall");

      check("final_queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
